// File: rtl/cic_pkg.sv
// Shared definitions for the CIC integrator/decimator.
// Holds accumulator width derivation, ratio clamp helper and the default
// accumulator type for the standard configuration.
package cic_pkg;

  localparam int CIC_DATA_WIDTH     = 16;
  localparam int CIC_NUM_STAGES     = 3;
  localparam int CIC_MAX_RATIO_LOG2 = 4;

  // Bit growth of an N-stage CIC is N*log2(R); this is the worst case.
  function automatic int cic_acc_width(input int data_width,
                                       input int num_stages,
                                       input int max_ratio_log2);
    return data_width + num_stages * max_ratio_log2;
  endfunction

  // Requests above the supported ratio saturate to the largest ratio.
  function automatic int cic_clamp_ratio(input int ratio_log2,
                                         input int max_ratio_log2);
    return (ratio_log2 > max_ratio_log2) ? max_ratio_log2 : ratio_log2;
  endfunction

  typedef logic [cic_acc_width(CIC_DATA_WIDTH, CIC_NUM_STAGES,
                               CIC_MAX_RATIO_LOG2)-1:0] acc_t;

endpackage

// File: rtl/cic_integrator_stage.sv
// One wrap-around integrator register of the CIC cascade.
// Ports: clk/rst_n, step (accumulate enable), clr (synchronous clear),
//        din (addend), acc (registered running sum).
module cic_integrator_stage #(
  parameter int ACC_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic                 clr,
  input  logic [ACC_WIDTH-1:0] din,
  output logic [ACC_WIDTH-1:0] acc
);

  // Modular add: overflow wraps on purpose, the comb section cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/cic_integrator_decim.sv
// CIC integrator cascade plus downsampler; keeps one result per 2^ratio samples.
// Ports: clk, rst_n, en, sync_clr, in_valid, in, ratio_log2 -> out, out_valid.
// Optional macro CIC_DECIM_ROUND_EN selects round-half-up instead of floor scaling.
module cic_integrator_decim
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_STAGES     = 3,
  parameter int MAX_RATIO_LOG2 = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  sync_clr,
  input  logic                                  in_valid,
  input  logic [DATA_WIDTH-1:0]                 in,
  input  logic [$clog2(MAX_RATIO_LOG2+1)-1:0]   ratio_log2,
  output logic [DATA_WIDTH-1:0]                 out,
  output logic                                  out_valid
);

  localparam int ACC_WIDTH = cic_acc_width(DATA_WIDTH, NUM_STAGES, MAX_RATIO_LOG2);
  localparam int RW        = $clog2(MAX_RATIO_LOG2 + 1);
  localparam int SW        = $clog2(NUM_STAGES * MAX_RATIO_LOG2 + 1);
  localparam logic [MAX_RATIO_LOG2-1:0] CNT_ONE = 1;

  logic                      accept;
  logic                      clr;
  logic [ACC_WIDTH-1:0]      in_ext;
  logic [ACC_WIDTH-1:0]      acc      [NUM_STAGES];
  logic [ACC_WIDTH-1:0]      stage_din[NUM_STAGES];
  logic [MAX_RATIO_LOG2-1:0] cnt;
  logic [MAX_RATIO_LOG2-1:0] frame_mask;
  logic [RW-1:0]             ratio_q;
  logic [RW-1:0]             ratio_clamped;
  logic [RW-1:0]             ratio_eff;
  logic                      last;
  logic [SW-1:0]             shamt;
  logic [ACC_WIDTH-1:0]      acc_last_next;
  logic [ACC_WIDTH-1:0]      bias;
  logic signed [ACC_WIDTH-1:0] rounded;
  logic [DATA_WIDTH-1:0]     out_next;

  assign accept = en & ~sync_clr & in_valid;
  assign clr    = en & sync_clr;
  assign in_ext = {{(ACC_WIDTH-DATA_WIDTH){in[DATA_WIDTH-1]}}, in};

  // Each stage adds the pre-update value of its predecessor, so an input
  // needs NUM_STAGES accepted samples to reach the last stage.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign stage_din[g] = in_ext;
    end else begin : g_rest
      assign stage_din[g] = acc[g-1];
    end

    cic_integrator_stage #(.ACC_WIDTH(ACC_WIDTH)) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .step (accept),
      .clr  (clr),
      .din  (stage_din[g]),
      .acc  (acc[g])
    );
  end

  // Value the last integrator will hold after this edge.
  assign acc_last_next = acc[NUM_STAGES-1] + stage_din[NUM_STAGES-1];

  // The ratio is sampled only on the first sample of a frame and applies
  // to that very sample, so R=1 emits on the sample that loads it.
  assign ratio_clamped = RW'(cic_clamp_ratio(int'(ratio_log2), MAX_RATIO_LOG2));
  assign ratio_eff     = (cnt == '0) ? ratio_clamped : ratio_q;

  always_comb begin
    frame_mask = '0;
    for (int i = 0; i < MAX_RATIO_LOG2; i++) begin
      frame_mask[i] = (i < int'(ratio_eff));
    end
  end

  assign last  = (cnt == frame_mask);
  assign shamt = SW'(NUM_STAGES * int'(ratio_eff));

`ifdef CIC_DECIM_ROUND_EN
  assign bias = (shamt == '0) ? '0 : (ACC_WIDTH'(1) << (shamt - SW'(1)));
`else
  assign bias = '0;
`endif

  assign rounded  = acc_last_next + bias;
  assign out_next = DATA_WIDTH'(rounded >>> shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      ratio_q   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (!en) begin
      out_valid <= 1'b0;
    end else if (sync_clr) begin
      cnt       <= '0;
      ratio_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid & last;
      if (in_valid) begin
        if (cnt == '0) begin
          ratio_q <= ratio_eff;
        end
        cnt <= last ? '0 : cnt + CNT_ONE;
        if (last) begin
          out <= out_next;
        end
      end
    end
  end

endmodule
